vga_rect_mover: RTL and testbench

//  Motion controller for the VGA rectangle renderer. Once per frame, at the start of

---
 rtl/vga_rect_mover.sv | 165 ++++++++++++++++
 tb/tb_vga_rect_mover.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vga_rect_mover.sv
`default_nettype none
// ============================================================================
// Module   : vga_rect_mover
// Brief    : Per-frame bouncing motion controller for the VGA rectangle.
// Revision : 1.0 - initial release
// ============================================================================
module vga_rect_mover #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int WIDTH  = 20,
  parameter int HEIGHT = 100,
  parameter int STEP   = 2,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pos_h,
  input  logic [9:0] pos_v,
  input  logic       blank,
  input  logic       enable,
  output logic [9:0] x_left,
  output logic [9:0] y_bottom,
  output logic       dir_x,
  output logic       dir_y,
  output logic       frame_tick,
  output logic       bounce
);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_MOVE_X = 2'd1,
    S_MOVE_Y = 2'd2
  } state_t;

  localparam logic [10:0] c_h_res  = 11'(H_RES);
  localparam logic [10:0] c_v_res  = 11'(V_RES);
  localparam logic [10:0] c_width  = 11'(WIDTH);
  localparam logic [10:0] c_height = 11'(HEIGHT);
  localparam logic [10:0] c_step   = 11'(STEP);
  localparam logic [9:0]  c_step10 = 10'(STEP);
  localparam logic [9:0]  c_x_max  = 10'(H_RES - WIDTH);
  localparam logic [9:0]  c_y_max  = 10'(V_RES - HEIGHT);

  state_t      r_state, w_state_nxt;
  logic        r_fs, r_fs_prev, r_flag;
  logic        w_fs, w_flag_nxt, w_tick_nxt, w_bounce_nxt;
  logic        w_dx_nxt, w_dy_nxt;
  logic [9:0]  w_x_nxt, w_y_nxt;
  logic [10:0] w_x_ext, w_y_ext;
  logic        w_x_hit_hi, w_x_hit_lo, w_y_hit_hi, w_y_hit_lo;
  logic        w_unused_blank;

  // blank is informational only; the frame start is decoded from the counters
  assign w_unused_blank = blank;

  assign w_fs = (pos_v == 10'(V_RES)) && (pos_h == 10'd0);

  assign w_x_ext    = {1'b0, x_left};
  assign w_y_ext    = {1'b0, y_bottom};
  assign w_x_hit_hi = (w_x_ext + c_width + c_step) >= c_h_res;
  assign w_x_hit_lo = w_x_ext <= c_step;
  assign w_y_hit_hi = (w_y_ext + c_height + c_step) >= c_v_res;
  assign w_y_hit_lo = w_y_ext <= c_step;

  // Rising-edge detect so a stalled counter cannot retrigger; reset marks the
  // condition as already seen so a frame start coincident with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fs      <= 1'b0;
      r_fs_prev <= 1'b1;
    end else begin
      r_fs      <= w_fs & ~r_fs_prev;
      r_fs_prev <= w_fs;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_WAIT;
      r_flag     <= 1'b0;
      x_left     <= 10'(X_INIT);
      y_bottom   <= 10'(Y_INIT);
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
      frame_tick <= 1'b0;
      bounce     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_flag     <= w_flag_nxt;
      x_left     <= w_x_nxt;
      y_bottom   <= w_y_nxt;
      dir_x      <= w_dx_nxt;
      dir_y      <= w_dy_nxt;
      frame_tick <= w_tick_nxt;
      bounce     <= w_bounce_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_flag_nxt   = r_flag;
    w_x_nxt      = x_left;
    w_y_nxt      = y_bottom;
    w_dx_nxt     = dir_x;
    w_dy_nxt     = dir_y;
    w_tick_nxt   = 1'b0;
    w_bounce_nxt = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (r_fs) begin
          w_tick_nxt = 1'b1;
          w_flag_nxt = 1'b0;
          if (enable) w_state_nxt = S_MOVE_X;
        end
      end
      S_MOVE_X: begin
        if (dir_x) begin
          if (w_x_hit_hi) begin
            w_x_nxt    = c_x_max;
            w_dx_nxt   = 1'b0;
            w_flag_nxt = 1'b1;
          end else begin
            w_x_nxt = x_left + c_step10;
          end
        end else begin
          if (w_x_hit_lo) begin
            w_x_nxt    = 10'd0;
            w_dx_nxt   = 1'b1;
            w_flag_nxt = 1'b1;
          end else begin
            w_x_nxt = x_left - c_step10;
          end
        end
        w_state_nxt = S_MOVE_Y;
      end
      S_MOVE_Y: begin
        // X and Y hits merge into a single pulse
        w_bounce_nxt = r_flag;
        if (dir_y) begin
          if (w_y_hit_hi) begin
            w_y_nxt      = c_y_max;
            w_dy_nxt     = 1'b0;
            w_bounce_nxt = 1'b1;
          end else begin
            w_y_nxt = y_bottom + c_step10;
          end
        end else begin
          if (w_y_hit_lo) begin
            w_y_nxt      = 10'd0;
            w_dy_nxt     = 1'b1;
            w_bounce_nxt = 1'b1;
          end else begin
            w_y_nxt = y_bottom - c_step10;
          end
        end
        w_flag_nxt  = 1'b0;
        w_state_nxt = S_WAIT;
      end
      default: w_state_nxt = S_WAIT;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_rect_mover.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_rect_mover
// Brief    : Directed self-checking bench for vga_rect_mover.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_rect_mover;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       blank = 1'b1;
  logic [9:0] pos_h = 10'd0;
  logic [9:0] pos_v_a = 10'd0, pos_v_b = 10'd0, pos_v_c = 10'd0;
  logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
  logic       dx_a, dy_a, tk_a, bn_a;
  logic       dx_b, dy_b, tk_b, bn_b;
  logic       dx_c, dy_c, tk_c, bn_c;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vga_rect_mover u_dut_a (
    .clk(clk), .reset(reset), .pos_h(pos_h), .pos_v(pos_v_a), .blank(blank), .enable(enable),
    .x_left(x_a), .y_bottom(y_a), .dir_x(dx_a), .dir_y(dy_a), .frame_tick(tk_a), .bounce(bn_a)
  );

  vga_rect_mover #(.X_INIT(619)) u_dut_b (
    .clk(clk), .reset(reset), .pos_h(pos_h), .pos_v(pos_v_b), .blank(blank), .enable(enable),
    .x_left(x_b), .y_bottom(y_b), .dir_x(dx_b), .dir_y(dy_b), .frame_tick(tk_b), .bounce(bn_b)
  );

  // Small screen so an odd coordinate moving down-left reaches (1,1) quickly
  vga_rect_mover #(.H_RES(41), .V_RES(41), .WIDTH(20), .HEIGHT(20),
                   .X_INIT(19), .Y_INIT(19)) u_dut_c (
    .clk(clk), .reset(reset), .pos_h(pos_h), .pos_v(pos_v_c), .blank(blank), .enable(enable),
    .x_left(x_c), .y_bottom(y_c), .dir_x(dx_c), .dir_y(dy_c), .frame_tick(tk_c), .bounce(bn_c)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Presents the frame-start pixel for one edge; returns just after that edge (N)
  task automatic fire(input int sel);
    @(posedge clk); #1;
    case (sel)
      0: pos_v_a = 10'd480;
      1: pos_v_b = 10'd480;
      default: pos_v_c = 10'd41;
    endcase
    pos_h = 10'd0;
    @(posedge clk); #1;
    pos_v_a = 10'd0; pos_v_b = 10'd0; pos_v_c = 10'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(); step();
    vectors++; if (x_a !== 10'd320) begin miscompares++; $display("FAIL reset_x got %0d want 320", x_a); end
    vectors++; if (y_a !== 10'd240) begin miscompares++; $display("FAIL reset_y got %0d want 240", y_a); end
    vectors++; if ({dx_a, dy_a} !== 2'b11) begin miscompares++; $display("FAIL reset_dirs got %b want 11", {dx_a, dy_a}); end
    vectors++; if ({tk_a, bn_a} !== 2'b00) begin miscompares++; $display("FAIL reset_tick_bounce got %b want 00", {tk_a, bn_a}); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_move();
    enable = 1'b1;
    fire(0);
    step();
    vectors++; if (tk_a !== 1'b1) begin miscompares++; $display("FAIL move_tick_n1 got %b want 1", tk_a); end
    vectors++; if (x_a !== 10'd320) begin miscompares++; $display("FAIL move_x_n1 got %0d want 320", x_a); end
    step();
    vectors++; if (x_a !== 10'd322) begin miscompares++; $display("FAIL move_x_n2 got %0d want 322", x_a); end
    vectors++; if (y_a !== 10'd240) begin miscompares++; $display("FAIL move_y_n2 got %0d want 240", y_a); end
    vectors++; if (tk_a !== 1'b0) begin miscompares++; $display("FAIL move_tick_n2 got %b want 0", tk_a); end
    step();
    vectors++; if (y_a !== 10'd242) begin miscompares++; $display("FAIL move_y_n3 got %0d want 242", y_a); end
    vectors++; if (bn_a !== 1'b0) begin miscompares++; $display("FAIL move_bounce got %b want 0", bn_a); end
    vectors++; if ({dx_a, dy_a} !== 2'b11) begin miscompares++; $display("FAIL move_dirs got %b want 11", {dx_a, dy_a}); end
  endtask

  task automatic test_right_edge();
    fire(1);
    step(); step();
    vectors++; if (x_b !== 10'd620) begin miscompares++; $display("FAIL edge_x got %0d want 620", x_b); end
    vectors++; if (dx_b !== 1'b0) begin miscompares++; $display("FAIL edge_dir_x got %b want 0", dx_b); end
    step();
    vectors++; if (bn_b !== 1'b1) begin miscompares++; $display("FAIL edge_bounce got %b want 1", bn_b); end
    vectors++; if (y_b !== 10'd242) begin miscompares++; $display("FAIL edge_y got %0d want 242", y_b); end
    step();
    vectors++; if (bn_b !== 1'b0) begin miscompares++; $display("FAIL edge_bounce_end got %b want 0", bn_b); end
    fire(1);
    step(); step(); step();
    vectors++; if (x_b !== 10'd618) begin miscompares++; $display("FAIL edge_x_next got %0d want 618", x_b); end
  endtask

  task automatic test_corner();
    int pulses = 0;
    for (int f = 0; f < 11; f++) begin
      fire(2);
      step(); step(); step(); step();
    end
    vectors++; if ({x_c, y_c} !== {10'd1, 10'd1}) begin miscompares++; $display("FAIL corner_pre got x=%0d y=%0d want 1 1", x_c, y_c); end
    vectors++; if ({dx_c, dy_c} !== 2'b00) begin miscompares++; $display("FAIL corner_pre_dirs got %b want 00", {dx_c, dy_c}); end
    fire(2);
    for (int i = 0; i < 6; i++) begin
      step();
      if (bn_c === 1'b1) pulses++;
    end
    vectors++; if ({x_c, y_c} !== 20'd0) begin miscompares++; $display("FAIL corner_pos got x=%0d y=%0d want 0 0", x_c, y_c); end
    vectors++; if ({dx_c, dy_c} !== 2'b11) begin miscompares++; $display("FAIL corner_dirs got %b want 11", {dx_c, dy_c}); end
    vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL corner_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_freeze();
    int ticks = 0;
    int bounces = 0;
    enable = 1'b0;
    for (int f = 0; f < 3; f++) begin
      fire(0);
      for (int i = 0; i < 4; i++) begin
        step();
        if (tk_a === 1'b1) ticks++;
        if (bn_a === 1'b1) bounces++;
      end
    end
    vectors++; if (ticks !== 3) begin miscompares++; $display("FAIL freeze_ticks got %0d want 3", ticks); end
    vectors++; if (bounces !== 0) begin miscompares++; $display("FAIL freeze_bounces got %0d want 0", bounces); end
    vectors++; if ({x_a, y_a} !== {10'd322, 10'd242}) begin miscompares++; $display("FAIL freeze_pos got x=%0d y=%0d want 322 242", x_a, y_a); end
    vectors++; if ({dx_a, dy_a} !== 2'b11) begin miscompares++; $display("FAIL freeze_dirs got %b want 11", {dx_a, dy_a}); end
  endtask

  task automatic test_reset_mid_update();
    enable = 1'b1;
    fire(0);
    step(); step();
    vectors++; if (x_a !== 10'd324) begin miscompares++; $display("FAIL mid_x_n2 got %0d want 324", x_a); end
    reset = 1'b0;
    step();
    reset = 1'b1;
    vectors++; if ({x_a, y_a} !== {10'd320, 10'd240}) begin miscompares++; $display("FAIL mid_reset_pos got x=%0d y=%0d want 320 240", x_a, y_a); end
    step(); step();
    vectors++; if ({x_a, y_a} !== {10'd320, 10'd240}) begin miscompares++; $display("FAIL mid_no_partial got x=%0d y=%0d want 320 240", x_a, y_a); end
    fire(0);
    step(); step();
    vectors++; if (x_a !== 10'd322) begin miscompares++; $display("FAIL mid_resume_x got %0d want 322", x_a); end
    step();
    vectors++; if (y_a !== 10'd242) begin miscompares++; $display("FAIL mid_resume_y got %0d want 242", y_a); end
  endtask

  task automatic test_fs_during_reset();
    int ticks = 0;
    step();
    reset = 1'b0;
    pos_v_a = 10'd480;
    step();
    reset = 1'b1;
    pos_v_a = 10'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (tk_a === 1'b1) ticks++;
    end
    vectors++; if (ticks !== 0) begin miscompares++; $display("FAIL fs_in_reset_ticks got %0d want 0", ticks); end
    vectors++; if (x_a !== 10'd320) begin miscompares++; $display("FAIL fs_in_reset_x got %0d want 320", x_a); end
  endtask

  initial begin
    test_reset();
    test_move();
    test_right_edge();
    test_corner();
    test_freeze();
    test_reset_mid_update();
    test_fs_during_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1);
  end

endmodule
`default_nettype wire
